alu_op_scheduler: RTL

// - Buffered command front-end for the IEEE-754 ALU (alu). Accepts tagged operations over a valid/ready port.
// - Queues operations in a DEPTH-entry FIFO and issues them one at a time using the ALU start/valid_out handshake.
// - Returns tagged results over a valid/ready port and accumulates IEEE sticky exception flags.
// - Sits between the command source (CPU/bus adapter, vector driver) and one alu instance.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/alu_op_scheduler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command scheduler.
// - Opcode constants as presented to the IEEE-754 ALU.
// - Bit positions inside the 5-bit exception flag vector.
// - Precision-mode encoding and the scheduler FSM state encoding.
// - hp_mask(): clears the upper half-word of a value in half-precision mode.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Flag vector layout: {invalid, div_by_zero, overflow, underflow, inexact}
  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  localparam logic MODE_SP = 1'b1;
  localparam logic MODE_HP = 1'b0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2,
    StResp  = 2'd3
  } sched_state_e;

  // Half-precision values live in [15:0]; whatever sits above is not part of the operand.
  function automatic logic [31:0] hp_mask(input logic [31:0] data, input logic mode_fp,
                                          input bit enable);
    return (enable && (mode_fp == MODE_HP)) ? {16'h0000, data[15:0]} : data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read port.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, wdata     write request and data (ignored while full)
//   pop             read request (ignored while empty); rdata shows the head entry
//   full, empty     occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Buffered command front-end for one IEEE-754 ALU instance.
// Commands (operands, opcode, precision, rounding, tag) are queued in a FIFO and issued one
// at a time over the ALU start/valid_out handshake; tagged results come back in command order
// over a valid/ready port, and exception flags are accumulated into sticky_flags.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready, in_*          command port (in_ready = FIFO not full)
//   alu_op_a/b, alu_op_code, alu_mode_fp, alu_round_mode, alu_start   to the ALU
//   alu_result, alu_valid_out, alu_flags                               from the ALU
//   out_valid/out_ready, out_result, out_flags, out_tag, out_timeout   response port
//   sticky_flags, sticky_clr         accumulated flags and their clear
//   busy                             FIFO non-empty or an op in flight
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter bit          HP_MASK = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op_a,
  input  logic [31:0]      in_op_b,
  input  logic [2:0]       in_op_code,
  input  logic             in_mode_fp,
  input  logic             in_round_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  output logic [2:0]       alu_op_code,
  output logic             alu_mode_fp,
  output logic             alu_round_mode,
  output logic             alu_start,
  input  logic [31:0]      alu_result,
  input  logic             alu_valid_out,
  input  logic [4:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_timeout,
  output logic [4:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic             busy
);

  localparam int unsigned PAYLOAD_W = TAG_W + 1 + 1 + 3 + 32 + 32;
  localparam int unsigned TCNT_W    = $clog2(TIMEOUT) + 1;

  // FIFO interface
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAYLOAD_W-1:0] fifo_wdata, fifo_rdata;

  // Head-of-queue fields
  logic [31:0]      head_a, head_b;
  logic [2:0]       head_code;
  logic             head_mode, head_round;
  logic [TAG_W-1:0] head_tag;

  // State
  sched_state_e     state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]       op_code_q, op_code_d;
  logic             mode_q, mode_d, round_q, round_d, start_q, start_d;
  logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
  logic             out_valid_q, out_valid_d, out_timeout_q, out_timeout_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [4:0]       out_flags_q, out_flags_d, sticky_q, sticky_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_wdata = {in_tag, in_round_mode, in_mode_fp, in_op_code, in_op_b, in_op_a};

  assign head_a     = fifo_rdata[31:0];
  assign head_b     = fifo_rdata[63:32];
  assign head_code  = fifo_rdata[66:64];
  assign head_mode  = fifo_rdata[67];
  assign head_round = fifo_rdata[68];
  assign head_tag   = fifo_rdata[69 +: TAG_W];

  sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    fifo_pop      = 1'b0;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_code_d     = op_code_q;
    mode_d        = mode_q;
    round_d       = round_q;
    start_d       = start_q;
    issue_tag_d   = issue_tag_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_flags_d   = out_flags_q;
    out_tag_d     = out_tag_q;
    out_timeout_d = out_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          op_a_d      = hp_mask(head_a, head_mode, HP_MASK);
          op_b_d      = hp_mask(head_b, head_mode, HP_MASK);
          op_code_d   = head_code;
          mode_d      = head_mode;
          round_d     = head_round;
          issue_tag_d = head_tag;
          start_d     = 1'b1;
          tcnt_d      = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        tcnt_d = tcnt_q + 1'b1;
        if (alu_valid_out) begin
          start_d       = 1'b0;
          out_result_d  = hp_mask(alu_result, mode_q, HP_MASK);
          out_flags_d   = alu_flags;
          out_tag_d     = issue_tag_q;
          out_timeout_d = 1'b0;
          state_d       = StDrain;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          // ALU never answered: abort and report a clean, zeroed result.
          start_d       = 1'b0;
          out_result_d  = '0;
          out_flags_d   = '0;
          out_tag_d     = issue_tag_q;
          out_timeout_d = 1'b1;
          state_d       = StDrain;
        end
      end
      StDrain: begin
        // Let the ALU drop valid_out so it cannot be mistaken for the next op's result.
        if (!alu_valid_out) begin
          out_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A clear coinciding with a handshake still keeps the flags of the op completing now.
  always_comb begin
    sticky_d = sticky_q;
    if (out_valid_q && out_ready) begin
      sticky_d = (sticky_clr ? 5'b0 : sticky_q) | out_flags_q;
    end else if (sticky_clr) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tcnt_q        <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_code_q     <= '0;
      mode_q        <= 1'b0;
      round_q       <= 1'b0;
      start_q       <= 1'b0;
      issue_tag_q   <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_tag_q     <= '0;
      out_timeout_q <= 1'b0;
      sticky_q      <= '0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_code_q     <= op_code_d;
      mode_q        <= mode_d;
      round_q       <= round_d;
      start_q       <= start_d;
      issue_tag_q   <= issue_tag_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_flags_q   <= out_flags_d;
      out_tag_q     <= out_tag_d;
      out_timeout_q <= out_timeout_d;
      sticky_q      <= sticky_d;
    end
  end

  assign alu_op_a       = op_a_q;
  assign alu_op_b       = op_b_q;
  assign alu_op_code    = op_code_q;
  assign alu_mode_fp    = mode_q;
  assign alu_round_mode = round_q;
  assign alu_start      = start_q;
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_flags      = out_flags_q;
  assign out_tag        = out_tag_q;
  assign out_timeout    = out_timeout_q;
  assign sticky_flags   = sticky_q;
  assign busy           = !fifo_empty || (state_q != StIdle);

endmodule
